// File: rtl/pdm_pkg.sv
// Shared mode encoding and frame helpers for the multi-channel PDM/PWM generator.
package pdm_pkg;

  localparam logic MODE_PDM = 1'b0;
  localparam logic MODE_PWM = 1'b1;

  // Number of cycles in one frame for a given level resolution.
  function automatic int unsigned frame_len(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage

// File: rtl/pdm_multichannel_gen_channel.sv
// One output channel: active level, first-order accumulator and output flop.
module pdm_channel
  import pdm_pkg::*;
#(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             commit,
  input  logic             clear,
  input  logic             mode,
  input  logic [WIDTH-1:0] shadow_level,
  input  logic [WIDTH-1:0] frame_cnt_next,
  output logic             pdm_out
);

  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             out_q, out_d;
  logic [WIDTH:0]   sum;

  // Next level, accumulator and output bit; the commit edge already uses the new level and mode.
  always_comb begin
    level_d = commit ? shadow_level : level_q;
    acc_d   = acc_q;
    out_d   = 1'b0;
    sum     = {1'b0, acc_q} + {1'b0, level_d};
    if (clear) begin
      acc_d = '0;
    end else if (mode == MODE_PDM) begin
      acc_d = sum[WIDTH-1:0];
    end
    if (mode == MODE_PWM) begin
      out_d = (frame_cnt_next < level_d);
    end else if (!clear) begin
      out_d = sum[WIDTH];
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      acc_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  assign pdm_out = out_q;

endmodule

// File: rtl/pdm_multichannel_gen.sv
// Multi-channel PDM/PWM level generator with frame-aligned, double-buffered updates.
module pdm_multichannel_gen
  import pdm_pkg::*;
#(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ADDR_W   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                mode_in,
  output logic [CHANNELS-1:0] pdm_out,
  output logic                frame_start
);

  localparam logic [WIDTH-1:0] FRAME_LAST = WIDTH'(frame_len(WIDTH) - 32'd1);

  logic [WIDTH-1:0]                frame_cnt_q, frame_cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  shadow_level_q, shadow_level_d;
  logic                            shadow_mode_q, shadow_mode_d;
  logic                            active_mode_q, active_mode_d;
  logic                            frame_start_q, frame_start_d;
  logic                            commit;
  logic                            mode_clear;

  // Frame counter, shadow capture with address decode, and commit/mode-change detection.
  always_comb begin
    frame_cnt_d    = frame_cnt_q + WIDTH'(1);
    commit         = (frame_cnt_q == FRAME_LAST);
    shadow_level_d = shadow_level_q;
    shadow_mode_d  = shadow_mode_q;
    if (write_en) begin
      shadow_mode_d = mode_in;
      for (int ch = 0; ch < int'(CHANNELS); ch++) begin
        if (wr_addr == ADDR_W'(ch)) begin
          shadow_level_d[ch] = wr_data;
        end
      end
    end
    active_mode_d = commit ? shadow_mode_q : active_mode_q;
    mode_clear    = commit && (shadow_mode_q != active_mode_q);
    frame_start_d = (frame_cnt_d == '0);
  end

  // Shared control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q    <= '0;
      shadow_level_q <= '0;
      shadow_mode_q  <= MODE_PDM;
      active_mode_q  <= MODE_PDM;
      frame_start_q  <= 1'b0;
    end else begin
      frame_cnt_q    <= frame_cnt_d;
      shadow_level_q <= shadow_level_d;
      shadow_mode_q  <= shadow_mode_d;
      active_mode_q  <= active_mode_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign frame_start = frame_start_q;

  // Independent per-channel generators.
  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
    pdm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk            (clk),
      .reset          (reset),
      .commit         (commit),
      .clear          (mode_clear),
      .mode           (active_mode_d),
      .shadow_level   (shadow_level_q[g]),
      .frame_cnt_next (frame_cnt_d),
      .pdm_out        (pdm_out[g])
    );
  end

endmodule
